// File: rtl/mtm_alu_frame_tx_if.sv
// rtl/mtm_alu_frame_tx_if.sv - packet request handshake between ALU result source and frame transmitter
interface mtm_alu_frame_tx_if #(
  parameter int DATA_BYTES = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [8*DATA_BYTES-1:0]   in_data;
  logic [3:0]                in_flags;
  logic                      in_err;
  logic [5:0]                in_err_code;

  modport master (
    output in_valid, in_data, in_flags, in_err, in_err_code,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_data, in_flags, in_err, in_err_code,
    output in_ready
  );
endinterface

// File: rtl/mtm_alu_frame_tx.sv
// rtl/mtm_alu_frame_tx.sv - serialises an ALU result (data frames + ctl frame) or an error frame onto sout
module mtm_alu_frame_tx #(
  parameter int DATA_BYTES = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  mtm_alu_frame_tx_if.slave bus,
  output logic              sout,
  output logic              busy,
  output logic              tx_done
);
  localparam int DW = 8 * DATA_BYTES;

  typedef enum logic [2:0] {S_IDLE, S_START, S_TYPE, S_PAYLOAD, S_STOP} state_t;

  state_t        r_state, w_state_next;
  logic [2:0]    r_bit_cnt, w_bit_cnt_next;
  logic [1:0]    r_stop_cnt, w_stop_cnt_next;
  logic [3:0]    r_byte_cnt, w_byte_cnt_next;
  logic [DW-1:0] r_data, w_data_next;
  logic [3:0]    r_flags, w_flags_next;
  logic          r_err, w_err_next;
  logic [5:0]    r_err_code, w_err_code_next;
  logic [2:0]    r_crc, w_crc_next, w_crc_in;
  logic          r_sout, r_busy, r_tx_done;
  logic          w_sout_next, w_busy_next, w_tx_done_next;
  logic          w_ready, w_xfer;
  logic [7:0]    w_byte_next;

  // CRC-3 (x^3+x+1) over {data, flags}, MSB first, zero init
  function automatic logic [2:0] crc3(input logic [DW-1:0] d, input logic [3:0] f);
    logic [DW+3:0] msg;
    logic [2:0]    c;
    logic          fb;
    msg = {d, f};
    c   = 3'b000;
    for (int i = DW + 3; i >= 0; i--) begin
      fb = c[2] ^ msg[i];
      c  = {c[1:0], 1'b0} ^ {1'b0, fb, fb};
    end
    return c;
  endfunction

  // Byte carried by the frame selected by the byte counter (0 selects the ctl frame)
  function automatic logic [7:0] frame_byte(input logic [3:0] cnt, input logic [DW-1:0] d,
                                            input logic [3:0] f, input logic [2:0] c,
                                            input logic e, input logic [5:0] code);
    logic [7:0] b;
    b = {1'b0, f, c};
    if (e) begin
      b = {1'b1, code, ^{1'b1, code}};
    end else begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (cnt == 4'(i + 1)) b = d[8*i +: 8];
      end
    end
    return b;
  endfunction

  assign w_ready      = (r_state == S_IDLE) && !rst;
  assign w_xfer       = w_ready && bus.in_valid;
  assign w_crc_in     = crc3(bus.in_data, bus.in_flags);
  assign bus.in_ready = w_ready;
  assign sout         = r_sout;
  assign busy         = r_busy;
  assign tx_done      = r_tx_done;

  // Next-state logic; line outputs are derived from the next state so they come straight from flops
  always_comb begin
    w_state_next    = r_state;
    w_bit_cnt_next  = r_bit_cnt;
    w_stop_cnt_next = r_stop_cnt;
    w_byte_cnt_next = r_byte_cnt;
    w_data_next     = r_data;
    w_flags_next    = r_flags;
    w_err_next      = r_err;
    w_err_code_next = r_err_code;
    w_crc_next      = r_crc;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_state_next    = S_START;
          w_data_next     = bus.in_data;
          w_flags_next    = bus.in_flags;
          w_err_next      = bus.in_err;
          w_err_code_next = bus.in_err_code;
          w_crc_next      = w_crc_in;
          w_byte_cnt_next = bus.in_err ? 4'd0 : 4'(DATA_BYTES);
        end
      end
      S_START: w_state_next = S_TYPE;
      S_TYPE: begin
        w_state_next   = S_PAYLOAD;
        w_bit_cnt_next = 3'd7;
      end
      S_PAYLOAD: begin
        if (r_bit_cnt == 3'd0) begin
          w_state_next    = S_STOP;
          w_stop_cnt_next = 2'd1;
        end else begin
          w_bit_cnt_next = r_bit_cnt - 3'd1;
        end
      end
      S_STOP: begin
        if (r_stop_cnt == 2'(STOP_BITS)) begin
          if (r_byte_cnt == 4'd0) begin
            w_state_next = S_IDLE;
          end else begin
            w_state_next    = S_START;
            w_byte_cnt_next = r_byte_cnt - 4'd1;
          end
        end else begin
          w_stop_cnt_next = r_stop_cnt + 2'd1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    w_byte_next = frame_byte(w_byte_cnt_next, w_data_next, w_flags_next, w_crc_next,
                             w_err_next, w_err_code_next);
    w_sout_next = 1'b1;
    case (w_state_next)
      S_START:   w_sout_next = 1'b0;
      S_TYPE:    w_sout_next = w_err_next | (w_byte_cnt_next == 4'd0);
      S_PAYLOAD: w_sout_next = w_byte_next[w_bit_cnt_next];
      default:   w_sout_next = 1'b1;
    endcase
    w_busy_next    = (w_state_next != S_IDLE);
    w_tx_done_next = (w_state_next == S_STOP) && (w_stop_cnt_next == 2'(STOP_BITS)) &&
                     (w_byte_cnt_next == 4'd0);
  end

  // State, captured packet and registered line outputs; reset aborts any packet at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 3'd0;
      r_stop_cnt <= 2'd0;
      r_byte_cnt <= 4'd0;
      r_data     <= '0;
      r_flags    <= 4'd0;
      r_err      <= 1'b0;
      r_err_code <= 6'd0;
      r_crc      <= 3'd0;
      r_sout     <= 1'b1;
      r_busy     <= 1'b0;
      r_tx_done  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_stop_cnt <= w_stop_cnt_next;
      r_byte_cnt <= w_byte_cnt_next;
      r_data     <= w_data_next;
      r_flags    <= w_flags_next;
      r_err      <= w_err_next;
      r_err_code <= w_err_code_next;
      r_crc      <= w_crc_next;
      r_sout     <= w_sout_next;
      r_busy     <= w_busy_next;
      r_tx_done  <= w_tx_done_next;
    end
  end
endmodule

// File: tb/tb_mtm_alu_frame_tx.sv
// tb/tb_mtm_alu_frame_tx.sv - self-checking bench for mtm_alu_frame_tx against a packet-level model
module tb_mtm_alu_frame_tx;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mtm_alu_frame_tx_if #(.DATA_BYTES(4)) a_if ();
  mtm_alu_frame_tx_if #(.DATA_BYTES(2)) b_if ();
  logic a_sout, a_busy, a_done;
  logic b_sout, b_busy, b_done;

  mtm_alu_frame_tx #(.DATA_BYTES(4), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave), .sout(a_sout), .busy(a_busy), .tx_done(a_done)
  );
  mtm_alu_frame_tx #(.DATA_BYTES(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave), .sout(b_sout), .busy(b_busy), .tx_done(b_done)
  );

  int checks = 0;
  int errors = 0;
  logic       exp_q[$];
  logic [7:0] obs_bytes[$];
  logic       obs_types[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Remainder of M(x)*x^3 divided by x^3+x+1, by polynomial long division
  function automatic logic [2:0] model_crc(input logic [63:0] data, input int db, input logic [3:0] flags);
    logic [74:0] m;
    m = '0;
    for (int k = 0; k < 8 * db; k++) m[k + 7] = data[k];
    m[6:3] = flags;
    for (int i = 8 * db + 6; i >= 3; i--) begin
      if (m[i]) m[i -: 4] = m[i -: 4] ^ 4'b1011;
    end
    return m[2:0];
  endfunction

  function automatic void push_frame(input logic t, input logic [7:0] b, input int sb);
    exp_q.push_back(1'b0);
    exp_q.push_back(t);
    for (int j = 7; j >= 0; j--) exp_q.push_back(b[j]);
    for (int j = 0; j < sb; j++) exp_q.push_back(1'b1);
  endfunction

  function automatic void build(input int db, input int sb, input logic [63:0] data,
                                input logic [3:0] flags, input logic err, input logic [5:0] code);
    exp_q.delete();
    if (err) begin
      push_frame(1'b1, {1'b1, code, ^{1'b1, code}}, sb);
    end else begin
      for (int k = db - 1; k >= 0; k--) push_frame(1'b0, data[8*k +: 8], sb);
      push_frame(1'b1, {1'b0, flags, model_crc(data, db, flags)}, sb);
    end
  endfunction

  task automatic run_a(input logic [31:0] d, input logic [3:0] f, input logic e,
                       input logic [5:0] c, input string tag);
    int n;
    int pos;
    logic [7:0] acc;
    acc = 8'h00;
    @(negedge clk);
    a_if.in_valid = 1'b1; a_if.in_data = d; a_if.in_flags = f;
    a_if.in_err = e; a_if.in_err_code = c;
    chk({tag, " ready"}, a_if.in_ready, 1);
    build(4, 1, {32'h0, d}, f, e, c);
    n = exp_q.size();
    obs_bytes.delete();
    obs_types.delete();
    @(negedge clk);
    a_if.in_valid = 1'b0;
    a_if.in_data = $urandom;
    a_if.in_flags = 4'($urandom);
    a_if.in_err = 1'($urandom);
    a_if.in_err_code = 6'($urandom);
    for (int i = 0; i < n; i++) begin
      if (i == 3) a_if.in_valid = 1'b1;
      if (i == n - 2) a_if.in_valid = 1'b0;
      chk({tag, " sout"}, a_sout, exp_q[i]);
      chk({tag, " busy"}, a_busy, 1);
      chk({tag, " tx_done"}, a_done, (i == n - 1) ? 1 : 0);
      pos = i % 11;
      if (pos == 1) obs_types.push_back(a_sout);
      if (pos >= 2 && pos <= 9) acc = {acc[6:0], a_sout};
      if (pos == 9) obs_bytes.push_back(acc);
      @(negedge clk);
    end
    chk({tag, " idle sout"}, a_sout, 1);
    chk({tag, " idle busy"}, a_busy, 0);
    chk({tag, " idle ready"}, a_if.in_ready, 1);
    chk({tag, " idle tx_done"}, a_done, 0);
  endtask

  initial begin
    int n;
    logic [15:0] bd;
    logic [3:0]  bf;
    rst = 1'b1;
    a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.in_flags = '0; a_if.in_err = 1'b0; a_if.in_err_code = '0;
    b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.in_flags = '0; b_if.in_err = 1'b0; b_if.in_err_code = '0;
    repeat (2) @(negedge clk);
    chk("reset sout", a_sout, 1);
    chk("reset ready", a_if.in_ready, 0);
    chk("reset busy", a_busy, 0);
    chk("reset tx_done", a_done, 0);
    chk("reset b sout", b_sout, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("post reset ready", a_if.in_ready, 1);
    chk("post reset sout", a_sout, 1);

    run_a(32'h0, 4'b0000, 1'b0, 6'd0, "zero");
    chk("zero nbytes", obs_bytes.size(), 5);
    chk("zero ctl", obs_bytes[4], 8'h00);

    run_a(32'h0, 4'b0010, 1'b0, 6'd0, "crc");
    chk("crc ctl", obs_bytes[4], 8'h16);
    chk("crc type", obs_types[4], 1);

    run_a(32'hA1B2C3D4, 4'($urandom), 1'b0, 6'($urandom), "order");
    chk("order b0", obs_bytes[0], 8'hA1);
    chk("order b1", obs_bytes[1], 8'hB2);
    chk("order b2", obs_bytes[2], 8'hC3);
    chk("order b3", obs_bytes[3], 8'hD4);
    for (int k = 0; k < 4; k++) chk("order type", obs_types[k], 0);

    run_a($urandom, 4'($urandom), 1'b1, 6'b100100, "err");
    chk("err nbytes", obs_bytes.size(), 1);
    chk("err byte", obs_bytes[0], 8'hC9);
    chk("err type", obs_types[0], 1);

    for (int r = 0; r < 8; r++) begin
      run_a($urandom, 4'($urandom), ($urandom_range(0, 3) == 0), 6'($urandom), "rand");
    end

    // abort in the second data frame
    @(negedge clk);
    a_if.in_valid = 1'b1; a_if.in_data = $urandom; a_if.in_err = 1'b0;
    @(negedge clk);
    a_if.in_valid = 1'b0;
    repeat (13) @(negedge clk);
    chk("abort busy before", a_busy, 1);
    rst = 1'b1;
    #1;
    chk("abort sout", a_sout, 1);
    chk("abort busy", a_busy, 0);
    chk("abort tx_done", a_done, 0);
    chk("abort ready", a_if.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      chk("after abort tx_done", a_done, 0);
      chk("after abort sout", a_sout, 1);
    end
    run_a($urandom, 4'($urandom), 1'b0, 6'd0, "after abort");

    // DATA_BYTES=2, STOP_BITS=2 with in_valid held across back-to-back packets
    bd = 16'($urandom);
    bf = 4'($urandom);
    @(negedge clk);
    b_if.in_valid = 1'b1; b_if.in_data = bd; b_if.in_flags = bf; b_if.in_err = 1'b0;
    chk("b ready", b_if.in_ready, 1);
    build(2, 2, {48'h0, bd}, bf, 1'b0, 6'd0);
    n = exp_q.size();
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < n; i++) begin
        if (p == 1 && i == 0) b_if.in_valid = 1'b0;
        chk("b sout", b_sout, exp_q[i]);
        chk("b busy", b_busy, 1);
        chk("b tx_done", b_done, (i == n - 1) ? 1 : 0);
        @(negedge clk);
      end
      chk("b idle sout", b_sout, 1);
      chk("b idle ready", b_if.in_ready, 1);
      chk("b idle busy", b_busy, 0);
      @(negedge clk);
    end
    chk("b final busy", b_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
